// File: rtl/count_share_arbiter_if.sv
// count_share_arbiter_if: requester-side bundle for the shared counter arbiter
interface count_share_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 4
);
  logic [NUM_REQ-1:0]       req_i;
  logic [NUM_REQ*CNT_W-1:0] len_i;
  logic [NUM_REQ-1:0]       gnt_o;
  logic [NUM_REQ-1:0]       done_o;
  logic                     busy_o;
  logic [CNT_W-1:0]         count_o;
  modport master (output req_i, len_i, input gnt_o, done_o, busy_o, count_o);
  modport slave  (input req_i, len_i, output gnt_o, done_o, busy_o, count_o);
endinterface

// File: rtl/count_share_arbiter.sv
// count_share_arbiter: round-robin owner of a shared loadable up-counter
// Define COUNT_SHARE_ABORT_EN to let a granted requester cancel its run by dropping req.
module count_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  count_share_arbiter_if.slave  bus
);
  localparam int PW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e             state_q;
  logic [NUM_REQ-1:0] gnt_q, done_q;
  logic               busy_q;
  logic [CNT_W-1:0]   count_q, len_q;
  logic [PW-1:0]      ptr_q, ptr_d, w_q, win;
  // descending scan so the lowest offset from ptr_q wins
  always_comb begin
    win = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_i[(int'(ptr_q) + i) % NUM_REQ]) win = PW'((int'(ptr_q) + i) % NUM_REQ);
    end
    ptr_d = PW'((int'(win) + 1) % NUM_REQ);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
      len_q   <= '0;
      ptr_q   <= '0;
      w_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (|bus.req_i) begin
          state_q <= RUN;
          gnt_q   <= NUM_REQ'(1) << win;
          busy_q  <= 1'b1;
          count_q <= '0;
          len_q   <= bus.len_i[win*CNT_W +: CNT_W];
          ptr_q   <= ptr_d;
          w_q     <= win;
        end
        RUN: begin
`ifdef COUNT_SHARE_ABORT_EN
          if (!bus.req_i[w_q]) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
          end else
`endif
          if (count_q == len_q) begin
            state_q <= DONE;
            gnt_q   <= '0;
            done_q  <= gnt_q;
          end else begin
            count_q <= count_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
  assign bus.gnt_o   = gnt_q;
  assign bus.done_o  = done_q;
  assign bus.busy_o  = busy_q;
  assign bus.count_o = count_q;
endmodule

// File: doc/count_share_arbiter.md
# count_share_arbiter

Round-robin scheduler that shares one loadable up-counter between up to `NUM_REQ` requesters. Each requester asks for a timed window of `len+1` cycles. The arbiter grants one requester and latches its length. It then runs the shared counter from 0 up to that length and signals completion with a one-cycle done pulse. It sits between the requesting engines and the shared 4-bit count datapath, and is the sole owner of that counter's load and advance controls.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `CNT_W`, default 4: counter and length width.

Ports:
- `clk`, input, 1: clock. Rising edge.
- `reset`, input, 1: reset, asynchronous, active-high.
- `req_i`, input, `NUM_REQ`: request, one bit per requester. Level; held until `done_o`.
- `len_i`, input, `NUM_REQ*CNT_W`: length per requester. Requester k uses bits `[k*CNT_W +: CNT_W]`.
- `gnt_o`, output, `NUM_REQ`: one-hot grant, registered.
- `done_o`, output, `NUM_REQ`: one-cycle completion pulse, registered.
- `busy_o`, output, 1: high in RUN and DONE.
- `count_o`, output, `CNT_W`: shared counter value.

## Operation
- States: IDLE, RUN, DONE. Encoded internally; not exported.
- IDLE:
  - If any `req_i` is set, select the winner by round-robin: the first set bit at or above `ptr`, wrapping modulo `NUM_REQ`.
  - On the clock edge: set `gnt_o[w]`, latch `len_q <= len_i[w]`, set `count_o <= 0`, set `ptr <= (w+1) mod NUM_REQ`, and go to RUN.
  - No request: hold all outputs; `count_o` retains its last value.
- RUN:
  - If `count_o == len_q`: go to DONE, clear `gnt_o`, set `done_o[w]`, and hold `count_o`.
  - Otherwise: `count_o <= count_o + 1`.
  - Arithmetic is unsigned `CNT_W`-bit. Because `len_q` never exceeds the maximum value, the counter never wraps.
- DONE: clear `done_o` and go to IDLE. Requests are not evaluated in this state.
- `len_i` changes after the grant are ignored, because `len_q` is latched.
- A requester whose `req_i` is still high in IDLE after its done pulse is treated as a new request. It competes under round-robin and has lowest priority relative to its own last grant.
- Simultaneous requests: exactly one grant is issued. `gnt_o` and `done_o` are never more than one-hot.
- Reset (any time, including mid-RUN): state IDLE, `gnt_o=0`, `done_o=0`, `busy_o=0`, `count_o=0`, `ptr=0`, `len_q=0`. A run interrupted by reset produces no done pulse.

## Timing
- Request to grant: `gnt_o` rises on the first rising edge at which the block is in IDLE and samples `req_i` high. Latency is 1 cycle.
- Grant window: `gnt_o[w]` is high for exactly `len_q+1` cycles. During the window `count_o` shows 0, 1, …, `len_q`.
- `len_q=0`: grant lasts 1 cycle and `count_o=0`; done follows on the next edge.
- `done_o[w]`: a single cycle, immediately following the last grant cycle.
- Back-to-back service: the sequence is DONE, then one IDLE cycle, then the next grant. The minimum gap between grants to different requesters is 2 cycles with `gnt_o=0`.
- `busy_o` is registered and is high from the first grant cycle through the DONE cycle.

## Configuration
- `COUNT_SHARE_ABORT_EN` defined:
  - In RUN, if `req_i[w]` is sampled low, go to IDLE on that edge.
  - Clear `gnt_o` and `busy_o`; do not assert `done_o`.
  - `count_o` holds the value it had at the abort edge.
  - `ptr` is already advanced.
- `COUNT_SHARE_ABORT_EN` undefined:
  - `req_i[w]` is ignored after the grant.
  - The run always completes to `len_q` and produces `done_o[w]`.

## Test plan
- Reset mid-RUN:
  - Stimulus: requester 1 with `len=5` is granted and `count_o` has reached 3; assert `reset`.
  - Response: all outputs are 0 immediately, no `done_o` pulse occurs, and after release the next grant goes to the lowest-indexed active requester.
- Single request:
  - Stimulus: `req_i=4'b0100`, `len_i[2]=3`.
  - Response: `gnt_o=4'b0100` for 4 cycles, `count_o` reads 0, 1, 2, 3, then `done_o=4'b0100` for 1 cycle, then `busy_o` drops.
- Round-robin fairness:
  - Stimulus: `req_i=4'b1111` held, all lengths 0.
  - Response: grants follow the order 0, 1, 2, 3, 0, each 1 cycle long, separated by 2-cycle gaps.
- Zero and maximum lengths:
  - `len=0` gives a 1-cycle grant.
  - `len=15` (`CNT_W=4`) gives a 16-cycle grant, with `count_o` ending at 15 and not wrapping.
- Simultaneous requests:
  - Stimulus: `ptr=2` and `req_i=4'b1011`.
  - Response: the grant goes to requester 3 and `ptr` becomes 0.
  - Verify one-hot `gnt_o` every cycle.
- Abort:
  - Stimulus: requester 0 with `len=6` drops `req_i` when `count_o=2`.
  - With `COUNT_SHARE_ABORT_EN`: the grant clears on the next edge, no done pulse occurs, and `count_o` holds 2.
  - Without the macro: the run completes to 6 and `done_o[0]` pulses.
